// File: rtl/vx_gpr_bank_arbiter_pkg.sv
// Shared definitions for the GPR bank arbiter slice.
// Holds machine-wide widths, the request record, the perf counter alias
// and small sizing helpers used to derive localparams.
package vx_gpr_bank_arbiter_pkg;

    localparam int NUM_THREADS   = 4;
    localparam int PERF_CTR_BITS = 44;
    localparam int GPR_ADDR_W    = 8;

    typedef logic [PERF_CTR_BITS-1:0] perf_ctr_t;

    typedef struct packed {
        logic [GPR_ADDR_W-1:0] addr;
    } gpr_req_t;

    // Bank select bits for a power-of-two bank count.
    function automatic int bank_bits(input int num_banks);
        return (num_banks > 1) ? $clog2(num_banks) : 1;
    endfunction

    // Requester index width, never narrower than one bit.
    function automatic int req_bits(input int num_reqs);
        return (num_reqs > 1) ? $clog2(num_reqs) : 1;
    endfunction

endpackage

// File: rtl/vx_gpr_bank_arbiter_if.sv
// Read request / response bus between the operand collectors and the
// GPR bank arbiter.
//   req_valid/req_addr : collector -> arbiter read request
//   req_ready          : arbiter -> collector, request granted this cycle
//   rsp_valid/rsp_data : arbiter -> collector, read data one cycle later
// master = collector side, slave = arbiter side.
interface vx_gpr_bank_arbiter_if
    import vx_gpr_bank_arbiter_pkg::*;
#(
    parameter int NUM_REQS = 4,
    parameter int ADDR_W   = 8,
    parameter int DATAW    = 32 * NUM_THREADS
);
    logic [NUM_REQS-1:0]             req_valid;
    logic [NUM_REQS-1:0][ADDR_W-1:0] req_addr;
    logic [NUM_REQS-1:0]             req_ready;
    logic [NUM_REQS-1:0]             rsp_valid;
    logic [NUM_REQS-1:0][DATAW-1:0]  rsp_data;

    modport master (
        output req_valid,
        output req_addr,
        input  req_ready,
        input  rsp_valid,
        input  rsp_data
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        output req_ready,
        output rsp_valid,
        output rsp_data
    );
endinterface

// File: rtl/vx_gpr_bank_arbiter_rr_bank_select.sv
// Round-robin winner selection for one GPR bank.
//   clk, reset : clock, asynchronous active-high reset
//   req_mask   : requesters targeting this bank
//   block      : bank is taken by a writeback this cycle
//   gnt_valid  : a read is granted on this bank
//   gnt_idx    : index of the granted requester
module vx_gpr_bank_arbiter_rr_bank_select #(
    parameter int NUM_REQS = 4,
    parameter int REQ_BITS = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_REQS-1:0] req_mask,
    input  logic                block,
    output logic                gnt_valid,
    output logic [REQ_BITS-1:0] gnt_idx
);

    logic [REQ_BITS-1:0] rr_ptr_r;
    logic                found_hi_s;
    logic                found_any_s;
    logic [REQ_BITS-1:0] win_hi_s;
    logic [REQ_BITS-1:0] win_any_s;

    // Lowest candidate at or above the pointer, and lowest candidate overall
    // (the wrap-around fallback). Scanning downward leaves the lowest index.
    always_comb begin
        found_hi_s  = 1'b0;
        found_any_s = 1'b0;
        win_hi_s    = '0;
        win_any_s   = '0;
        for (int i = NUM_REQS - 1; i >= 0; i--) begin
            if (req_mask[i]) begin
                found_any_s = 1'b1;
                win_any_s   = REQ_BITS'(i);
                if (REQ_BITS'(i) >= rr_ptr_r) begin
                    found_hi_s = 1'b1;
                    win_hi_s   = REQ_BITS'(i);
                end else begin
                    found_hi_s = found_hi_s;
                end
            end else begin
                found_any_s = found_any_s;
            end
        end
    end

    assign gnt_idx   = found_hi_s ? win_hi_s : win_any_s;
    assign gnt_valid = found_any_s && !block && !reset;

    // Pointer moves just past the winner on a grant, holds otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_r <= '0;
        end else if (gnt_valid) begin
            rr_ptr_r <= (gnt_idx == REQ_BITS'(NUM_REQS - 1)) ? '0 : gnt_idx + REQ_BITS'(1);
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

endmodule

// File: rtl/vx_gpr_bank_arbiter.sv
// GPR bank arbiter: maps NUM_REQS collector read requests onto NUM_BANKS
// single-ported synchronous-read banks. Writeback owns its bank for the
// cycle; reads are granted round-robin per bank and answered one cycle later.
//   clk, reset          : clock, asynchronous active-high reset
//   rd_if (slave)       : collector request/response bus
//   wb_valid/addr/data  : writeback request, never stalled
//   bank_rd_*           : bank read port (data returns the cycle after en)
//   bank_wr_*           : bank write port (wb_data broadcast)
//   perf_bank_conflicts : running count of denied request-cycles
module vx_gpr_bank_arbiter
    import vx_gpr_bank_arbiter_pkg::*;
#(
    parameter int NUM_REQS  = 4,
    parameter int NUM_BANKS = 4,
    parameter int ADDR_W    = 8,
    parameter int DATAW     = 32 * NUM_THREADS,
    parameter int PERF_W    = PERF_CTR_BITS
) (
    input  logic                                 clk,
    input  logic                                 reset,
    vx_gpr_bank_arbiter_if.slave                 rd_if,
    input  logic                                 wb_valid,
    input  logic [ADDR_W-1:0]                    wb_addr,
    input  logic [DATAW-1:0]                     wb_data,
    output logic [NUM_BANKS-1:0]                 bank_rd_en,
    output logic [NUM_BANKS-1:0][ADDR_W-bank_bits(NUM_BANKS)-1:0] bank_rd_addr,
    input  logic [NUM_BANKS-1:0][DATAW-1:0]      bank_rd_data,
    output logic [NUM_BANKS-1:0]                 bank_wr_en,
    output logic [NUM_BANKS-1:0][ADDR_W-bank_bits(NUM_BANKS)-1:0] bank_wr_addr,
    output logic [NUM_BANKS-1:0][DATAW-1:0]      bank_wr_data,
    output logic [PERF_W-1:0]                    perf_bank_conflicts
);

    localparam int BANK_BITS = bank_bits(NUM_BANKS);
    localparam int ROW_W     = ADDR_W - BANK_BITS;
    localparam int REQ_BITS  = req_bits(NUM_REQS);

    logic [NUM_REQS-1:0][BANK_BITS-1:0]  bank_s;
    logic [NUM_REQS-1:0][ROW_W-1:0]      row_s;
    logic [BANK_BITS-1:0]                wb_bank_s;
    logic [ROW_W-1:0]                    wb_row_s;
    logic [NUM_BANKS-1:0]                gnt_valid_s;
    logic [NUM_BANKS-1:0][REQ_BITS-1:0]  gnt_idx_s;
    logic [NUM_REQS-1:0]                 ready_s;
    logic [NUM_REQS-1:0][DATAW-1:0]      rsp_data_s;
    logic [PERF_W-1:0]                   denied_s;
    logic [NUM_REQS-1:0]                 gnt_q_r;
    logic [NUM_REQS-1:0][BANK_BITS-1:0]  bank_q_r;
    logic [PERF_W-1:0]                   perf_r;

    // Split every request address into bank (low bits) and row (high bits).
    always_comb begin
        for (int i = 0; i < NUM_REQS; i++) begin
            bank_s[i] = rd_if.req_addr[i][BANK_BITS-1:0];
            row_s[i]  = rd_if.req_addr[i][ADDR_W-1:BANK_BITS];
        end
    end

    assign wb_bank_s = wb_addr[BANK_BITS-1:0];
    assign wb_row_s  = wb_addr[ADDR_W-1:BANK_BITS];

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic [NUM_REQS-1:0] mask_s;

        // Candidates for this bank: valid requests whose bank field matches.
        always_comb begin
            for (int i = 0; i < NUM_REQS; i++) begin
                mask_s[i] = rd_if.req_valid[i] && (bank_s[i] == BANK_BITS'(b));
            end
        end

        assign bank_wr_en[b]   = wb_valid && (wb_bank_s == BANK_BITS'(b)) && !reset;
        assign bank_wr_addr[b] = reset ? '0 : wb_row_s;
        assign bank_wr_data[b] = reset ? '0 : wb_data;

        vx_gpr_bank_arbiter_rr_bank_select #(
            .NUM_REQS (NUM_REQS),
            .REQ_BITS (REQ_BITS)
        ) u_sel (
            .clk       (clk),
            .reset     (reset),
            .req_mask  (mask_s),
            .block     (bank_wr_en[b]),
            .gnt_valid (gnt_valid_s[b]),
            .gnt_idx   (gnt_idx_s[b])
        );

        assign bank_rd_en[b]   = gnt_valid_s[b];
        assign bank_rd_addr[b] = gnt_valid_s[b] ? row_s[gnt_idx_s[b]] : '0;
    end

    // A requester is ready when its own bank granted exactly its index.
    always_comb begin
        for (int i = 0; i < NUM_REQS; i++) begin
            ready_s[i] = gnt_valid_s[bank_s[i]] && (gnt_idx_s[bank_s[i]] == REQ_BITS'(i));
        end
    end

    assign rd_if.req_ready = ready_s;

    // Count requests left waiting this cycle (bank conflict or write-blocked).
    always_comb begin
        denied_s = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            denied_s = denied_s + PERF_W'(rd_if.req_valid[i] & ~ready_s[i]);
        end
    end

    // Remember who was granted and from which bank, so the data returning
    // next cycle is steered back to that requester.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gnt_q_r  <= '0;
            bank_q_r <= '0;
            perf_r   <= '0;
        end else begin
            gnt_q_r  <= rd_if.req_valid & ready_s;
            bank_q_r <= bank_s;
            perf_r   <= perf_r + denied_s;
        end
    end

    // Response data mux: bank RAM output selected by the registered bank.
    always_comb begin
        for (int i = 0; i < NUM_REQS; i++) begin
            rsp_data_s[i] = bank_rd_data[bank_q_r[i]];
        end
    end

    assign rd_if.rsp_valid   = gnt_q_r;
    assign rd_if.rsp_data    = rsp_data_s;
    assign perf_bank_conflicts = perf_r;

endmodule

// File: tb/tb_vx_gpr_bank_arbiter.sv
// Directed bench for the GPR bank arbiter (4 requesters, 4 banks).
module tb_vx_gpr_bank_arbiter;
    import vx_gpr_bank_arbiter_pkg::*;

    localparam int NR = 4;
    localparam int NB = 4;
    localparam int AW = 8;
    localparam int DW = 128;
    localparam int PW = 44;
    localparam int RW = 6;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   wb_valid;
    logic [AW-1:0]          wb_addr;
    logic [DW-1:0]          wb_data;
    logic [NB-1:0]          bank_rd_en;
    logic [NB-1:0][RW-1:0]  bank_rd_addr;
    logic [NB-1:0][DW-1:0]  bank_rd_data;
    logic [NB-1:0]          bank_wr_en;
    logic [NB-1:0][RW-1:0]  bank_wr_addr;
    logic [NB-1:0][DW-1:0]  bank_wr_data;
    logic [PW-1:0]          perf;

    int checks = 0;
    int passed = 0;

    vx_gpr_bank_arbiter_if #(.NUM_REQS(NR), .ADDR_W(AW), .DATAW(DW)) rd_if ();

    vx_gpr_bank_arbiter #(
        .NUM_REQS(NR), .NUM_BANKS(NB), .ADDR_W(AW), .DATAW(DW), .PERF_W(PW)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .rd_if               (rd_if.slave),
        .wb_valid            (wb_valid),
        .wb_addr             (wb_addr),
        .wb_data             (wb_data),
        .bank_rd_en          (bank_rd_en),
        .bank_rd_addr        (bank_rd_addr),
        .bank_rd_data        (bank_rd_data),
        .bank_wr_en          (bank_wr_en),
        .bank_wr_addr        (bank_wr_addr),
        .bank_wr_data        (bank_wr_data),
        .perf_bank_conflicts (perf)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] bank_word(input int b);
        return {32'(32'h1111_0000 + b), 32'h2222_2222, 32'h3333_3333, 32'(32'hCAFE_0000 + b)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        rd_if.req_valid   = 4'b0001;
        rd_if.req_addr[0] = 8'h05;
        wb_valid = 1'b1;
        wb_addr  = 8'h07;
        #1;
        checks++; if (rd_if.rsp_valid !== 4'b0000) $display("FAIL reset_rsp_valid got %b want 0000", rd_if.rsp_valid); else passed++;
        checks++; if (perf !== 44'd0) $display("FAIL reset_perf got %0d want 0", perf); else passed++;
        checks++; if (rd_if.req_ready !== 4'b0000) $display("FAIL reset_ready got %b want 0000", rd_if.req_ready); else passed++;
        checks++; if (bank_rd_en !== 4'b0000) $display("FAIL reset_rd_en got %b want 0000", bank_rd_en); else passed++;
        checks++; if (bank_wr_en !== 4'b0000) $display("FAIL reset_wr_en got %b want 0000", bank_wr_en); else passed++;
        tick();
        checks++; if (perf !== 44'd0) $display("FAIL reset_perf_held got %0d want 0", perf); else passed++;
        rd_if.req_valid = 4'b0000;
        wb_valid = 1'b0;
        reset = 1'b0;
        #1;
    endtask

    task automatic test_single_read();
        rd_if.req_valid   = 4'b0001;
        rd_if.req_addr[0] = 8'h05;
        #1;
        checks++; if (rd_if.req_ready !== 4'b0001) $display("FAIL single_ready got %b want 0001", rd_if.req_ready); else passed++;
        checks++; if (bank_rd_en !== 4'b0010) $display("FAIL single_rd_en got %b want 0010", bank_rd_en); else passed++;
        checks++; if (bank_rd_addr[1] !== 6'h01) $display("FAIL single_rd_addr got %h want 01", bank_rd_addr[1]); else passed++;
        tick();
        rd_if.req_valid = 4'b0000;
        checks++; if (rd_if.rsp_valid !== 4'b0001) $display("FAIL single_rsp_valid got %b want 0001", rd_if.rsp_valid); else passed++;
        checks++; if (rd_if.rsp_data[0] !== bank_word(1)) $display("FAIL single_rsp_data got %h want %h", rd_if.rsp_data[0], bank_word(1)); else passed++;
        checks++; if (perf !== 44'd0) $display("FAIL single_perf got %0d want 0", perf); else passed++;
    endtask

    task automatic test_conflict();
        logic [3:0] exp_rdy;
        rd_if.req_addr[0] = 8'h02;
        rd_if.req_addr[1] = 8'h06;
        rd_if.req_addr[2] = 8'h0A;
        rd_if.req_valid   = 4'b0111;
        for (int k = 0; k < 3; k++) begin
            exp_rdy = 4'b0001 << k;
            #1;
            checks++; if (rd_if.req_ready !== exp_rdy) $display("FAIL conflict_ready[%0d] got %b want %b", k, rd_if.req_ready, exp_rdy); else passed++;
            checks++; if (bank_rd_addr[2] !== 6'(k)) $display("FAIL conflict_rd_addr[%0d] got %h want %h", k, bank_rd_addr[2], 6'(k)); else passed++;
            tick();
            checks++; if (rd_if.rsp_valid !== exp_rdy) $display("FAIL conflict_rsp_valid[%0d] got %b want %b", k, rd_if.rsp_valid, exp_rdy); else passed++;
            checks++; if (rd_if.rsp_data[k] !== bank_word(2)) $display("FAIL conflict_rsp_data[%0d] got %h want %h", k, rd_if.rsp_data[k], bank_word(2)); else passed++;
            rd_if.req_valid[k] = 1'b0;
        end
        checks++; if (perf !== 44'd3) $display("FAIL conflict_perf got %0d want 3", perf); else passed++;
    endtask

    task automatic test_conflict_free();
        for (int i = 0; i < NR; i++) rd_if.req_addr[i] = 8'(i);
        rd_if.req_valid = 4'b1111;
        #1;
        checks++; if (rd_if.req_ready !== 4'b1111) $display("FAIL free_ready got %b want 1111", rd_if.req_ready); else passed++;
        checks++; if (bank_rd_en !== 4'b1111) $display("FAIL free_rd_en got %b want 1111", bank_rd_en); else passed++;
        tick();
        rd_if.req_valid = 4'b0000;
        checks++; if (rd_if.rsp_valid !== 4'b1111) $display("FAIL free_rsp_valid got %b want 1111", rd_if.rsp_valid); else passed++;
        for (int i = 0; i < NR; i++) begin
            checks++; if (rd_if.rsp_data[i] !== bank_word(i)) $display("FAIL free_rsp_data[%0d] got %h want %h", i, rd_if.rsp_data[i], bank_word(i)); else passed++;
        end
        checks++; if (perf !== 44'd3) $display("FAIL free_perf got %0d want 3", perf); else passed++;
    endtask

    task automatic test_wb_priority();
        wb_valid = 1'b1;
        wb_addr  = 8'h07;
        wb_data  = {4{32'hDEAD_BEEF}};
        rd_if.req_addr[1] = 8'h0B;
        rd_if.req_valid   = 4'b0010;
        #1;
        checks++; if (rd_if.req_ready !== 4'b0000) $display("FAIL wb_ready_blocked got %b want 0000", rd_if.req_ready); else passed++;
        checks++; if (bank_wr_en !== 4'b1000) $display("FAIL wb_wr_en got %b want 1000", bank_wr_en); else passed++;
        checks++; if (bank_wr_addr[3] !== 6'h01) $display("FAIL wb_wr_addr got %h want 01", bank_wr_addr[3]); else passed++;
        checks++; if (bank_wr_data[3] !== {4{32'hDEAD_BEEF}}) $display("FAIL wb_wr_data got %h", bank_wr_data[3]); else passed++;
        checks++; if (bank_rd_en !== 4'b0000) $display("FAIL wb_rd_en got %b want 0000", bank_rd_en); else passed++;
        tick();
        wb_valid = 1'b0;
        checks++; if (perf !== 44'd4) $display("FAIL wb_perf got %0d want 4", perf); else passed++;
        #1;
        checks++; if (rd_if.req_ready !== 4'b0010) $display("FAIL wb_ready_after got %b want 0010", rd_if.req_ready); else passed++;
        checks++; if (bank_rd_addr[3] !== 6'h02) $display("FAIL wb_rd_addr_after got %h want 02", bank_rd_addr[3]); else passed++;
        tick();
        rd_if.req_valid = 4'b0000;
        checks++; if (rd_if.rsp_valid !== 4'b0010) $display("FAIL wb_rsp_valid got %b want 0010", rd_if.rsp_valid); else passed++;
        checks++; if (rd_if.rsp_data[1] !== bank_word(3)) $display("FAIL wb_rsp_data got %h want %h", rd_if.rsp_data[1], bank_word(3)); else passed++;
    endtask

    task automatic test_wrap();
        rd_if.req_addr[2] = 8'h04;
        rd_if.req_valid   = 4'b0100;
        #1;
        checks++; if (rd_if.req_ready !== 4'b0100) $display("FAIL wrap_setup_ready got %b want 0100", rd_if.req_ready); else passed++;
        tick();
        rd_if.req_addr[0] = 8'h00;
        rd_if.req_addr[3] = 8'h0C;
        rd_if.req_valid   = 4'b1001;
        #1;
        checks++; if (rd_if.req_ready !== 4'b1000) $display("FAIL wrap_first_ready got %b want 1000", rd_if.req_ready); else passed++;
        tick();
        rd_if.req_valid = 4'b0001;
        checks++; if (rd_if.rsp_valid !== 4'b1000) $display("FAIL wrap_first_rsp got %b want 1000", rd_if.rsp_valid); else passed++;
        checks++; if (perf !== 44'd5) $display("FAIL wrap_perf got %0d want 5", perf); else passed++;
        #1;
        checks++; if (rd_if.req_ready !== 4'b0001) $display("FAIL wrap_second_ready got %b want 0001", rd_if.req_ready); else passed++;
        tick();
        rd_if.req_valid = 4'b0000;
        checks++; if (rd_if.rsp_valid !== 4'b0001) $display("FAIL wrap_second_rsp got %b want 0001", rd_if.rsp_valid); else passed++;
        checks++; if (perf !== 44'd5) $display("FAIL wrap_perf_end got %0d want 5", perf); else passed++;
    endtask

    task automatic test_async_reset();
        rd_if.req_addr[0] = 8'h01;
        rd_if.req_valid   = 4'b0001;
        #1;
        checks++; if (rd_if.req_ready !== 4'b0001) $display("FAIL arst_grant got %b want 0001", rd_if.req_ready); else passed++;
        tick();
        rd_if.req_valid = 4'b0000;
        checks++; if (rd_if.rsp_valid !== 4'b0001) $display("FAIL arst_rsp_before got %b want 0001", rd_if.rsp_valid); else passed++;
        #2;
        reset = 1'b1;
        #1;
        checks++; if (rd_if.rsp_valid !== 4'b0000) $display("FAIL arst_rsp_dropped got %b want 0000", rd_if.rsp_valid); else passed++;
        checks++; if (perf !== 44'd0) $display("FAIL arst_perf got %0d want 0", perf); else passed++;
        #1;
        reset = 1'b0;
        rd_if.req_addr[0] = 8'h03;
        rd_if.req_addr[1] = 8'h02;
        rd_if.req_addr[2] = 8'h07;
        rd_if.req_addr[3] = 8'h0E;
        rd_if.req_valid   = 4'b1111;
        #1;
        checks++; if (rd_if.req_ready !== 4'b0011) $display("FAIL arst_lowest_first got %b want 0011", rd_if.req_ready); else passed++;
        tick();
        rd_if.req_valid = 4'b0000;
        checks++; if (rd_if.rsp_valid !== 4'b0011) $display("FAIL arst_rsp_after got %b want 0011", rd_if.rsp_valid); else passed++;
        checks++; if (perf !== 44'd2) $display("FAIL arst_perf_after got %0d want 2", perf); else passed++;
    endtask

    initial begin
        reset           = 1'b1;
        wb_valid        = 1'b0;
        wb_addr         = '0;
        wb_data         = '0;
        rd_if.req_valid = '0;
        rd_if.req_addr  = '0;
        for (int b = 0; b < NB; b++) bank_rd_data[b] = bank_word(b);

        test_reset();
        test_single_read();
        test_conflict();
        test_conflict_free();
        test_wb_priority();
        test_wrap();
        test_async_reset();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/vx_gpr_bank_arbiter.md
Name: VX_gpr_bank_arbiter

Overview:
- Arbitrates GPR read requests from NUM_REQS operand-collector units onto NUM_BANKS single-ported, synchronous-read register-file banks.
- Per-bank round-robin grant. Writeback always wins its bank for that cycle.
- Returns read data to the winning requester one cycle after grant.
- Sits between the operand collectors in the operand stage and the GPR bank RAMs; counts bank conflicts for perf.

Parameters:
- NUM_REQS, 4, number of requesting collector units (≥2, any value).
- NUM_BANKS, 4, number of GPR banks (power of 2, ≥2).
- ADDR_W, 8, full GPR address width (warp + register index).
- DATAW, 32*`NUM_THREADS, bank read/write data width.
- PERF_W, `PERF_CTR_BITS, conflict counter width.
- Derived (localparam): BANK_BITS = log2(NUM_BANKS); ROW_W = ADDR_W − BANK_BITS; REQ_BITS = max(1, clog2(NUM_REQS)).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  [NUM_REQS]  read request valid
- req_addr  in  [NUM_REQS][ADDR_W]  GPR address; bank = addr[BANK_BITS-1:0], row = upper bits
- req_ready  out  [NUM_REQS]  request granted this cycle
- rsp_valid  out  [NUM_REQS]  read data valid
- rsp_data  out  [NUM_REQS][DATAW]  read data
- wb_valid  in  1  writeback request
- wb_addr  in  ADDR_W  writeback address
- wb_data  in  DATAW  writeback data
- bank_rd_en  out  [NUM_BANKS]  bank read enable
- bank_rd_addr  out  [NUM_BANKS][ROW_W]  bank read row
- bank_rd_data  in  [NUM_BANKS][DATAW]  bank read data, valid the cycle after bank_rd_en
- bank_wr_en  out  [NUM_BANKS]  bank write enable
- bank_wr_addr  out  [NUM_BANKS][ROW_W]  bank write row
- bank_wr_data  out  [NUM_BANKS][DATAW]  bank write data (wb_data broadcast)
- perf_bank_conflicts  out  PERF_W  accumulated denied requests

Behaviour:
- Handshake: valid/ready. A requester holds req_valid and req_addr stable until req_ready. Each requester has at most one outstanding read.
- Write path (combinational): bank_wr_en[b] = wb_valid && wb bank == b. bank_wr_addr = wb row. A write is never stalled.
- Read grant (combinational), per bank b:
  - Candidates: valid requests whose bank == b.
  - If bank_wr_en[b] is set, no read grant on b.
  - Otherwise the winner is the first candidate at index ≥ rr_ptr[b], wrapping from NUM_REQS−1 to 0.
  - bank_rd_en[b] = 1 if a winner exists; bank_rd_addr[b] = winner's row; req_ready[winner] = 1.
  - Non-winners see ready 0. No combinational path from any ready to any valid.
- Pointer update (registered): on a grant in bank b, rr_ptr[b] <= (winner == NUM_REQS−1) ? 0 : winner+1. With no grant, rr_ptr[b] holds.
- Response (registered):
  - State: gnt_q[i] <= req_valid[i] && req_ready[i]; bank_q[i] <= bank of req_addr[i].
  - Outputs: rsp_valid[i] = gnt_q[i]; rsp_data[i] = bank_rd_data[bank_q[i]].
  - Latency is exactly 1 cycle from the grant edge. There is no backpressure on rsp; collectors must accept.
  - When rsp_valid[i] = 0, rsp_data[i] is don't-care.
- Simultaneous events:
  - A read and a write to the same row in the same cycle cannot occur: the write blocks the read.
  - A read granted the cycle after a write returns the new data (bank RAM property).
- Perf counter: each cycle, perf += number of requests with req_valid && !req_ready (conflict or write-blocked). Wraps modulo 2^PERF_W.
- Reset (asynchronous): rr_ptr = 0, gnt_q = 0, perf = 0. Therefore rsp_valid = 0 and perf_bank_conflicts = 0 immediately on assertion.
- Reset mid-operation: in-flight responses are dropped, not replayed. Combinational outputs (req_ready, bank_*) follow their inputs and are masked to 0 while reset is high.

Decomposition:
- Shared package (VX_gpu_pkg): BANK_BITS helper, gpr_req_t {addr}, and perf counter width alias.
- One natural sub-module: VX_rr_bank_select, one instance per bank. It holds the request mask, rr_ptr register, winner index, and a grant-valid signal.
- Top level handles bank decode, write priority, response pipeline and the perf counter.

Test Plan (NUM_REQS=4, NUM_BANKS=4):
- Single read: req0 addr 0x05 → same cycle ready0=1, bank_rd_en=4'b0010, bank_rd_addr[1]=0x01; next cycle rsp_valid0=1, rsp_data0=bank_rd_data[1].
- Three-way conflict: req0/1/2 all addr bank 2, held → grants 0, 1, 2 on cycles 0, 1, 2; rsp_valid follows each by 1 cycle; perf = 2+1+0 = 3.
- Conflict-free: req0..3 to banks 0..3 → all ready=1 same cycle, all rsp_valid=1 next cycle, perf unchanged.
- Writeback priority: wb_valid to bank 3 and req1 to bank 3 → ready1=0, bank_wr_en=4'b1000, perf+1; next cycle with wb idle → ready1=1.
- Wrap-around: after granting req2 on bank 0 (rr_ptr=3), req0 and req3 both to bank 0 → grant req3, then req0.
- Async reset between grant and response → rsp_valid drops to 0 without a clock edge; after release, a first conflict on any bank grants the lowest index.
